// File: rtl/vga_capture.sv
// VGA capture front end: registers the incoming raster, measures line and frame
// timing, locks onto the expected raster and emits visible pixels with coordinates.
module vga_capture #(
    parameter int H_LINE    = 1344,
    parameter int H_START   = 296,
    parameter int H_VISIBLE = 1024,
    parameter int V_FRAME   = 806,
    parameter int V_START   = 34,
    parameter int V_VISIBLE = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_start,
    output logic [10:0] line_total,
    output logic [10:0] frame_total,
    output logic        locked,
    output logic        timing_err
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] H_LINE_C  = 11'(H_LINE);
    localparam logic [10:0] V_FRAME_C = 11'(V_FRAME);
    localparam logic [10:0] H_OFF     = 11'(H_START);
    localparam logic [10:0] V_OFF     = 11'(V_START);
    localparam logic [11:0] H_LO      = 12'(H_START);
    localparam logic [11:0] H_HI      = 12'(H_START + H_VISIBLE);
    localparam logic [11:0] V_LO      = 12'(V_START);
    localparam logic [11:0] V_HI      = 12'(V_START + V_VISIBLE);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    // Input stage (S1) and the second sync register used for edge detection.
    logic        r_hs_s1;
    logic        r_vs_s1;
    logic        r_hs_s2;
    logic        r_vs_s2;
    logic [23:0] r_rgb_s1;

    // Raster position of the sample currently held in S1 is w_hpos/w_vline;
    // the registers keep the position of the previous sample.
    logic [10:0] r_hpos;
    logic [10:0] r_vline;
    logic        r_vs_pending;

    lock_state_t r_state;
    lock_state_t w_state_next;

    logic        r_pix_valid;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic [23:0] r_pix_data;
    logic        r_frame_start;
    logic [10:0] r_line_total;
    logic [10:0] r_frame_total;
    logic        r_timing_err;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_frame_edge;
    logic [10:0] w_hpos;
    logic [10:0] w_vline;
    logic [10:0] w_line_meas;
    logic [10:0] w_frame_meas;
    logic [10:0] w_hx;
    logic [10:0] w_vy;
    logic        w_visible;
    logic        w_line_err;
    logic        w_frame_err;
    logic        w_timing_err;

    // NOTE: every register below uses a synchronous reset and non-blocking
    // assignments, so all stages see the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_s1  <= 1'b0;
            r_vs_s1  <= 1'b0;
            r_hs_s2  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_rgb_s1 <= '0;
        end else begin
            r_hs_s1  <= hsync;
            r_vs_s1  <= vsync;
            r_hs_s2  <= r_hs_s1;
            r_vs_s2  <= r_vs_s1;
            r_rgb_s1 <= {red, green, blue};
        end
    end

    assign w_hs_fall    = r_hs_s2 & ~r_hs_s1;
    assign w_vs_fall    = r_vs_s2 & ~r_vs_s1;
    // A vsync edge seen earlier in the line, or on this very sample, starts the frame.
    assign w_frame_edge = w_hs_fall & (r_vs_pending | w_vs_fall);

    assign w_line_meas  = sat_inc(r_hpos);
    assign w_frame_meas = sat_inc(r_vline);
    assign w_hpos       = w_hs_fall ? 11'd0 : sat_inc(r_hpos);
    assign w_vline      = w_frame_edge ? 11'd0 :
                          w_hs_fall    ? sat_inc(r_vline) : r_vline;

    assign w_hx      = w_hpos - H_OFF;
    assign w_vy      = w_vline - V_OFF;
    assign w_visible = ({1'b0, w_hpos}  >= H_LO) && ({1'b0, w_hpos}  < H_HI) &&
                       ({1'b0, w_vline} >= V_LO) && ({1'b0, w_vline} < V_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hpos        <= '0;
            r_vline       <= '0;
            r_vs_pending  <= 1'b0;
            r_line_total  <= '0;
            r_frame_total <= '0;
        end else begin
            r_hpos  <= w_hpos;
            r_vline <= w_vline;
            if (w_hs_fall) begin
                r_vs_pending <= 1'b0;
                r_line_total <= w_line_meas;
            end else if (w_vs_fall) begin
                r_vs_pending <= 1'b1;
            end
            if (w_frame_edge) begin
                r_frame_total <= w_frame_meas;
            end
        end
    end

    assign w_line_err  = w_hs_fall & (w_line_meas != H_LINE_C);
    assign w_frame_err = w_frame_edge & (w_frame_meas != V_FRAME_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaults first, so no path through the case can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_timing_err = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_frame_edge) begin
                    w_state_next = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (w_line_err || w_frame_err) begin
                    w_state_next = ST_UNLOCKED;
                end else if (w_frame_edge) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_line_err || w_frame_err) begin
                    w_state_next = ST_UNLOCKED;
                    w_timing_err = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_data    <= '0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            r_frame_start <= w_frame_edge;
            r_timing_err  <= w_timing_err;
            if (w_visible && (r_state == ST_LOCKED)) begin
                r_pix_valid <= 1'b1;
                r_pix_x     <= w_hx[9:0];
                r_pix_y     <= w_vy[9:0];
                r_pix_data  <= r_rgb_s1;
            end else begin
                // Coordinates hold their last value outside the visible window.
                r_pix_valid <= 1'b0;
                r_pix_data  <= '0;
            end
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_data    = r_pix_data;
    assign frame_start = r_frame_start;
    assign line_total  = r_line_total;
    assign frame_total = r_frame_total;
    assign locked      = (r_state == ST_LOCKED);
    assign timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: a small raster generator drives sync/rgb and a
// per-cycle observer gathers event statistics that are asserted after each phase.
module tb_vga_capture;

    localparam int H_LINE    = 32;
    localparam int H_START   = 9;
    localparam int H_VISIBLE = 20;
    localparam int V_FRAME   = 16;
    localparam int V_START   = 4;
    localparam int V_VISIBLE = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [7:0]  red = '0;
    logic [7:0]  green = '0;
    logic [7:0]  blue = '0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_data;
    logic        frame_start;
    logic [10:0] line_total;
    logic [10:0] frame_total;
    logic        locked;
    logic        timing_err;

    vga_capture #(
        .H_LINE(H_LINE), .H_START(H_START), .H_VISIBLE(H_VISIBLE),
        .V_FRAME(V_FRAME), .V_START(V_START), .V_VISIBLE(V_VISIBLE)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .line_total(line_total), .frame_total(frame_total),
        .locked(locked), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    // One driven sample: raster line/clock as the generator sees them.
    typedef struct {
        int          l;
        int          c;
        logic [23:0] rgb;
        bit          rst;
    } samp_t;

    samp_t d1;
    samp_t d2;
    int    total = 0;
    int    bad = 0;
    int    vs_cnt = 0;
    bit    locked_prev = 1'b0;

    int fs_cnt, fs_pos_bad, te_cnt, te_l, te_c, te_lt, te_ft, te_misalign;
    int valid_cnt, valid_after_te, xy_bad, data_bad;
    int lock_rise_fs, lock_rise_nofs, rst_checks, rst_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        fs_cnt = 0; fs_pos_bad = 0; te_cnt = 0; te_l = -1; te_c = -1; te_lt = -1; te_ft = -1;
        te_misalign = 0; valid_cnt = 0; valid_after_te = 0; xy_bad = 0; data_bad = 0;
        lock_rise_fs = -1; lock_rise_nofs = 0; rst_checks = 0; rst_bad = 0;
    endtask

    // Outputs seen now belong to sample d2 (2-clock latency); a reset driven with d1 clears them.
    task automatic observe();
        if (d1.rst) begin
            rst_checks++;
            fs_cnt = 0;
            if (pix_valid || pix_x != 0 || pix_y != 0 || pix_data != 0 || frame_start ||
                line_total != 0 || frame_total != 0 || locked || timing_err)
                rst_bad++;
        end
        if (frame_start) begin
            fs_cnt++;
            if (d2.l != 0 || d2.c != 0) fs_pos_bad++;
        end
        if (locked && !locked_prev) begin
            lock_rise_fs = fs_cnt;
            if (!frame_start) lock_rise_nofs++;
        end
        if (timing_err) begin
            te_cnt++;
            te_l  = d2.l;
            te_c  = d2.c;
            te_lt = int'(line_total);
            te_ft = int'(frame_total);
            if (locked || !locked_prev) te_misalign++;
        end
        if (pix_valid) begin
            valid_cnt++;
            if (te_cnt > 0) valid_after_te++;
            if (int'(pix_x) != d2.c - H_START || int'(pix_y) != d2.l - V_START) xy_bad++;
            if (pix_data !== d2.rgb) data_bad++;
        end else if (pix_data !== 24'd0) begin
            data_bad++;
        end
        locked_prev = locked;
    endtask

    task automatic drive(input bit hs, input bit vs, input bit r, input int l, input int c);
        samp_t s;
        @(negedge clk);
        observe();
        s.l   = l;
        s.c   = c;
        s.rgb = 24'($urandom);
        s.rst = r;
        hsync = hs;
        vsync = vs;
        rst   = r;
        {red, green, blue} = s.rgb;
        d2 = d1;
        d1 = s;
    endtask

    // hsync low for 4 clocks per line; vsync low for 2 lines, starting either
    // on this frame's first sample (coinc) or at clock 2 of its last line (lag_end).
    task automatic send_frame(input int n_lines, input int long_line, input int long_len,
                              input bit coinc, input bit lag_end,
                              input int rst_line, input int rst_clk);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            len = (l == long_line) ? long_len : H_LINE;
            for (int c = 0; c < len; c++) begin
                if ((coinc && l == 0 && c == 0) || (lag_end && l == n_lines - 1 && c == 2))
                    vs_cnt = 2 * H_LINE;
                drive(c >= 4, vs_cnt == 0, (l == rst_line && c == rst_clk), l, c);
                if (vs_cnt > 0) vs_cnt--;
            end
        end
    endtask

    initial begin
        d1 = '{l: -1, c: -1, rgb: 24'd0, rst: 1'b1};
        d2 = d1;
        clear_stats();

        // Reset state
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, -1, -1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_line_total", line_total, 0);
        check("rst_frame_total", frame_total, 0);
        check("rst_locked", locked, 0);
        check("rst_timing_err", timing_err, 0);

        // Clean acquisition: lock at the second frame_start, then a full locked frame
        clear_stats();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, -1, -1);
        send_frame(16, -1, 0, 1'b1, 1'b1, -1, -1);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("acq_fs_cnt", fs_cnt, 2);
        check("acq_fs_pos", fs_pos_bad, 0);
        check("acq_lock_rise_fs", lock_rise_fs, 2);
        check("acq_lock_with_fs", lock_rise_nofs, 0);
        check("acq_locked", locked, 1);
        check("acq_valid_cnt", valid_cnt, 200);
        check("acq_xy", xy_bad, 0);
        check("acq_data", data_bad, 0);
        check("acq_line_total", line_total, 32);
        check("acq_frame_total", frame_total, 16);
        check("acq_te_cnt", te_cnt, 0);

        // Line 5 stretched to 33 clocks while locked
        clear_stats();
        send_frame(16, 5, 33, 1'b0, 1'b1, -1, -1);
        check("long_te_cnt", te_cnt, 1);
        check("long_te_line", te_l, 6);
        check("long_te_clk", te_c, 0);
        check("long_te_line_total", te_lt, 33);
        check("long_te_align", te_misalign, 0);
        check("long_locked", locked, 0);
        check("long_valid_cnt", valid_cnt, 40);
        check("long_valid_after", valid_after_te, 0);
        check("long_data", data_bad, 0);

        // Relock two frames later
        clear_stats();
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("relock_rise_fs", lock_rise_fs, 2);
        check("relock_valid_cnt", valid_cnt, 200);
        check("relock_xy", xy_bad, 0);
        check("relock_locked", locked, 1);

        // 17-line frame while locked
        clear_stats();
        send_frame(17, -1, 0, 1'b0, 1'b1, -1, -1);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("f17_te_cnt", te_cnt, 1);
        check("f17_te_line", te_l, 0);
        check("f17_frame_total", te_ft, 17);
        check("f17_te_align", te_misalign, 0);
        check("f17_valid_cnt", valid_cnt, 200);
        check("f17_valid_after", valid_after_te, 0);
        check("f17_locked", locked, 0);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("f17_relocked", locked, 1);

        // One-cycle reset mid-line while locked
        clear_stats();
        send_frame(16, -1, 0, 1'b0, 1'b1, 6, 15);
        check("mrst_checks", rst_checks, 1);
        check("mrst_outputs_zero", rst_bad, 0);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("mrst_fs_cnt_1", fs_cnt, 1);
        check("mrst_locked_after_1", locked, 0);
        send_frame(16, -1, 0, 1'b0, 1'b1, -1, -1);
        check("mrst_lock_rise_fs", lock_rise_fs, 2);
        check("mrst_locked_after_2", locked, 1);

        // hsync held high for 3000 clocks on visible line 5 while locked
        clear_stats();
        send_frame(16, 5, 3004, 1'b0, 1'b1, -1, -1);
        check("sat_te_cnt", te_cnt, 1);
        check("sat_line_total", te_lt, 2047);
        check("sat_te_line", te_l, 6);
        check("sat_valid_cnt", valid_cnt, 40);
        check("sat_locked", locked, 0);

        // vsync falling together with hsync marks the frame on that very line
        clear_stats();
        send_frame(16, -1, 0, 1'b0, 1'b0, -1, -1);
        send_frame(16, -1, 0, 1'b1, 1'b0, -1, -1);
        check("coinc_fs_cnt", fs_cnt, 2);
        check("coinc_fs_pos", fs_pos_bad, 0);
        check("coinc_lock_rise_fs", lock_rise_fs, 2);
        check("coinc_valid_cnt", valid_cnt, 200);
        check("coinc_xy", xy_bad, 0);
        check("coinc_data", data_bad, 0);
        check("coinc_frame_total", frame_total, 16);
        check("coinc_locked", locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_LINE 1344 total clocks per line;
  H_START 296 hpos of first visible pixel (H_SYNC+H_BACK);
  H_VISIBLE 1024 visible pixels per line;
  V_FRAME 806 total lines per frame;
  V_START 34 vline of first visible line (V_SYNC+V_BACK-1, vsync lags hsync within a line);
  V_VISIBLE 768 visible lines per frame.
REQ-002 Ports (name, direction, width, meaning):
  clk in 1 pixel clock; the block has one clock.
  rst in 1 reset, synchronous, active-high.
  hsync in 1 horizontal sync, active-low.
  vsync in 1 vertical sync, active-low.
  red/green/blue in 8 each, pixel colour.
  pix_valid out 1 captured pixel valid.
  pix_x out 10 visible column.
  pix_y out 10 visible row.
  pix_data out 24 {red,green,blue}.
  frame_start out 1 one-cycle pulse at each frame boundary.
  line_total out 11 clocks measured in the last complete line.
  frame_total out 11 lines measured in the last complete frame.
  locked out 1 timing matches parameters.
  timing_err out 1 one-cycle pulse on lock loss.

Function
REQ-003 Input stage: hsync, vsync and rgb registered once (stage S1); edges detected between S1 and a second sync register.
REQ-004 hs_fall = S1 hsync 0 while previous S1 hsync 1; vs_fall defined likewise for vsync.
REQ-005 hpos (11 bit): 0 on the hs_fall sample; +1 per later sample; saturates at 2047.
REQ-006 On hs_fall, line_total <= previous hpos+1, saturating at 2047.
REQ-007 vs_pending is set on vs_fall and cleared on the next hs_fall.
REQ-008 On hs_fall with vs_pending set or vs_fall true, vline <= 0 and frame_start pulses with the vline update.
REQ-008a On the same event, frame_total <= previous vline+1, saturating at 2047.
REQ-009 On any other hs_fall, vline <= vline+1, saturating at 2047.
REQ-010 Visible sample: H_START <= hpos < H_START+H_VISIBLE and V_START <= vline < V_START+V_VISIBLE.
REQ-011 Outputs are registered one cycle after S1, so pin-to-output latency is 2 clocks.
REQ-012 For a visible sample in LOCKED, the outputs are:
  pix_valid = 1;
  pix_x = hpos-H_START;
  pix_y = vline-V_START;
  pix_data = S1 rgb.
REQ-013 Otherwise pix_valid = 0 and pix_data = 0; pix_x/pix_y hold their last value.
REQ-014 Lock FSM states: UNLOCKED, ACQUIRE, LOCKED; locked = (state == LOCKED).
REQ-015 UNLOCKED -> ACQUIRE on the first frame_start.
REQ-016 ACQUIRE -> LOCKED on the next frame_start, only if frame_total == V_FRAME and no line error occurred in that frame.
REQ-017 Line error: in ACQUIRE or LOCKED, an hs_fall with measured line_total != H_LINE.
REQ-018 ACQUIRE -> UNLOCKED on a line error or a frame_total mismatch; timing_err stays 0.
REQ-019 LOCKED -> UNLOCKED on a line error or frame_total != V_FRAME; timing_err pulses 1 cycle, aligned with locked falling.
REQ-020 Line and frame checks are ignored in UNLOCKED, so the first partial line and frame after reset are never errors.
REQ-021 Simultaneous hs_fall and vs_fall: treated as a frame boundary (REQ-008), and the line check still applies.
REQ-022 Sync glitches are not filtered; every edge is counted.

Reset
REQ-023 rst clears to 0: all registers, hpos, vline, vs_pending, all outputs; FSM returns to UNLOCKED.
REQ-024 rst mid-frame: outputs are 0 on the following cycle.
REQ-025 After rst, lock is reacquired only via REQ-015/016, which takes at least two frame_starts.

Verification
All scenarios use H_LINE 32, H_START 9, H_VISIBLE 20, V_FRAME 16, V_START 4, V_VISIBLE 10, driven by the matching generator timing (hsync low 4 clocks, vsync low 2 lines).
REQ-026 Three clean frames -> locked rises at the 2nd frame_start after the first one.
REQ-026a In the locked frame: exactly 200 pix_valid cycles, pix_x 0..19, pix_y 0..9, pix_data equal to input rgb delayed 2 clocks.
REQ-027 Stretch one line to 33 clocks while locked -> timing_err pulses once at that line's end, locked drops, pix_valid stays 0 until relock two frames later.
REQ-028 Frame of 17 lines while locked -> frame_total=17, timing_err pulse, locked=0.
REQ-029 rst asserted for 1 cycle mid-line while locked -> next cycle all outputs 0; the first frame_start puts the FSM in ACQUIRE; locked after the second.
REQ-030 hsync held high for 3000 clocks -> hpos saturates and line_total=2047 at the next hs_fall, with no counter wrap.
REQ-030a The same case while locked -> timing_err pulse.
REQ-031 vs_fall coincident with hs_fall -> vline=0 and frame_start on that line (no one-line offset), pix_y=0 at vline 4.
